// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register load-pending scoreboard.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data and release to the read ports.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_ready,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic [AW:0]         pend_cnt
);
  localparam int NREG = 1 << AW;

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;
  logic            wa_ok;
  logic            wb_ok;
  logic            claim_ok;
  logic            cnt_inc;
  logic            cnt_dec;

  assign wa_ok    = wa_en && (wa_addr != '0);
  assign wb_ok    = wb_en && (wb_addr != '0);
  assign claim_ok = claim_en && (claim_addr != '0);

  // A claim overrides a same-cycle release, so the counter only drops when the bit really clears.
  assign cnt_inc = claim_ok && !pending[claim_addr];
  assign cnt_dec = wb_ok && pending[wb_addr] && !(claim_ok && (claim_addr == wb_addr));

  always_comb begin
    pending_next = pending;
    if (wb_ok)    pending_next[wb_addr]    = 1'b0;
    if (claim_ok) pending_next[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      if (wb_ok) mem[wb_addr] <= wb_data;
      if (wa_ok) mem[wa_addr] <= wa_data;
      pending  <= pending_next;
      pend_cnt <= pend_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
  end

  // Port A is applied after port B so ALU data wins an address collision.
  always_comb begin : read_mux
    logic [AW-1:0] a;
    a        = '0;
    rd_data  = '0;
    rd_ready = '1;
    for (int k = 0; k < NRP; k++) begin
      a = rd_addr[k*AW +: AW];
      if (!rst && (a != '0)) begin
        rd_data[k*XLEN +: XLEN] = mem[a];
        rd_ready[k]             = !pending[a];
`ifdef RF_BYPASS_EN
        if (wb_ok && (wb_addr == a)) begin
          rd_data[k*XLEN +: XLEN] = wb_data;
          rd_ready[k]             = 1'b1;
        end
        if (wa_ok && (wa_addr == a)) rd_data[k*XLEN +: XLEN] = wa_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven vectors plus a reference-model scoreboard for regfile_mp.
// Honours RF_BYPASS_EN the same way the design does.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRP  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_ready;
  logic                wa_en;
  logic [AW-1:0]       wa_addr;
  logic [XLEN-1:0]     wa_data;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic [AW:0]         pend_cnt;

  regfile_mp #(.XLEN(XLEN), .AW(AW), .NRP(NRP)) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            wa_en;
    logic [AW-1:0]   wa_addr;
    logic [XLEN-1:0] wa_data;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            claim_en;
    logic [AW-1:0]   claim_addr;
    logic [AW-1:0]   rd0;
    logic [AW-1:0]   rd1;
    logic [XLEN-1:0] exp_rd0;
    int              exp_cnt;
    bit              chk;
  } vec_t;

  typedef struct {
    logic [NRP*XLEN-1:0] data;
    logic [NRP-1:0]      ready;
    logic [AW:0]         cnt;
  } exp_t;

  exp_t            sb[$];
  vec_t            tbl[12];
  logic [XLEN-1:0] m_mem [32];
  logic [31:0]     m_pend;
  int              total = 0;
  int              bad = 0;

  function automatic vec_t mk(input logic wae, input logic [AW-1:0] waa, input logic [XLEN-1:0] wad,
                              input logic wbe, input logic [AW-1:0] wba, input logic [XLEN-1:0] wbd,
                              input logic ce, input logic [AW-1:0] ca,
                              input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                              input logic [XLEN-1:0] e0, input int ec, input bit chk);
    vec_t v;
    v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
    v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd;
    v.claim_en = ce; v.claim_addr = ca;
    v.rd0 = r0; v.rd1 = r1;
    v.exp_rd0 = e0; v.exp_cnt = ec; v.chk = chk;
    return v;
  endfunction

  task automatic compareVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_pend = '0;
  endtask

  function automatic void modelRead(input vec_t v, input logic [AW-1:0] a,
                                    output logic [XLEN-1:0] d, output logic r);
    d = '0;
    r = 1'b1;
    if (a != 0) begin
      d = m_mem[a];
      r = !m_pend[a];
`ifdef RF_BYPASS_EN
      if (v.wb_en && v.wb_addr == a) begin
        d = v.wb_data;
        r = 1'b1;
      end
      if (v.wa_en && v.wa_addr == a) d = v.wa_data;
`else
      if (v.chk && 1'b0) d = '0;
`endif
    end
  endfunction

  task automatic modelStep(input vec_t v);
    if (v.wb_en && v.wb_addr != 0) begin
      m_mem[v.wb_addr]  = v.wb_data;
      m_pend[v.wb_addr] = 1'b0;
    end
    if (v.wa_en && v.wa_addr != 0) m_mem[v.wa_addr] = v.wa_data;
    if (v.claim_en && v.claim_addr != 0) m_pend[v.claim_addr] = 1'b1;
  endtask

  task automatic checkOutput(input vec_t v);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL sb_empty: got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    compareVal("rd_data", rd_data, e.data);
    compareVal("rd_ready", rd_ready, e.ready);
    compareVal("pend_cnt", pend_cnt, e.cnt);
    if (v.chk) begin
      compareVal("tbl_rd0", rd_data[XLEN-1:0], v.exp_rd0);
      compareVal("tbl_cnt", pend_cnt, v.exp_cnt);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t            e;
    logic [XLEN-1:0] d;
    logic            r;
    @(negedge clk);
    wa_en = v.wa_en; wa_addr = v.wa_addr; wa_data = v.wa_data;
    wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
    claim_en = v.claim_en; claim_addr = v.claim_addr;
    rd_addr = {v.rd1, v.rd0};
    modelRead(v, v.rd0, d, r);
    e.data[XLEN-1:0] = d;
    e.ready[0]       = r;
    modelRead(v, v.rd1, d, r);
    e.data[2*XLEN-1:XLEN] = d;
    e.ready[1]            = r;
    e.cnt = (AW+1)'($countones(m_pend));
    sb.push_back(e);
    #2;
    checkOutput(v);
    modelStep(v);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,        1, 7, 0,  0,  32'h0,        0, 1);
    tbl[1]  = mk(0, 0, 0,            1, 7, 32'h77,   0, 0, 5,  7,  32'hDEADBEEF, 1, 1);
    tbl[2]  = mk(0, 0, 0,            0, 0, 0,        1, 3, 7,  3,  32'h77,       0, 1);
    tbl[3]  = mk(1, 3, 32'h11,       1, 3, 32'h22,   0, 0, 5,  3,  32'hDEADBEEF, 1, 1);
    tbl[4]  = mk(1, 0, 32'h1234,     0, 0, 0,        1, 0, 3,  0,  32'h11,       0, 1);
    tbl[5]  = mk(0, 0, 0,            0, 0, 0,        1, 9, 0,  3,  32'h0,        0, 1);
    tbl[6]  = mk(0, 0, 0,            1, 9, 32'h55,   1, 9, 3,  9,  32'h11,       1, 1);
    tbl[7]  = mk(0, 0, 0,            0, 0, 0,        1, 9, 9,  0,  32'h55,       1, 1);
    tbl[8]  = mk(0, 0, 0,            1, 12, 32'hC,   0, 0, 9,  12, 32'h55,       1, 1);
    tbl[9]  = mk(0, 0, 0,            0, 0, 0,        0, 0, 12, 9,  32'hC,        1, 1);
    tbl[10] = mk(0, 0, 0,            1, 9, 32'hAA,   0, 0, 12, 9,  32'hC,        1, 1);
    tbl[11] = mk(0, 0, 0,            0, 0, 0,        0, 0, 9,  3,  32'hAA,       0, 1);

    rst = 1'b1;
    wa_en = 0; wa_addr = 0; wa_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    claim_en = 0; claim_addr = 0;
    rd_addr = {5'd7, 5'd5};
    modelReset();
    #12;
    compareVal("reset_rd_data", rd_data, 64'h0);
    compareVal("reset_rd_ready", rd_ready, 2'b11);
    compareVal("reset_pend_cnt", pend_cnt, 6'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) applyStimulus(tbl[i]);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 7, 1, 2, 0, 0, 0));
    @(negedge clk);
    wa_en = 0; wb_en = 0; claim_en = 0;
    rd_addr = {5'd7, 5'd5};
    #1;
    compareVal("pre_rst_rd0", rd_data[XLEN-1:0], 32'hDEADBEEF);
    compareVal("pre_rst_ready", rd_ready, 2'b01);
    compareVal("pre_rst_cnt", pend_cnt, 6'd1);
    rst = 1'b1;
    #1;
    compareVal("mid_rst_rd_data", rd_data, 64'h0);
    compareVal("mid_rst_rd_ready", rd_ready, 2'b11);
    compareVal("mid_rst_cnt", pend_cnt, 6'd0);
    #1;
    rst = 1'b0;
    modelReset();
    #1;
    compareVal("post_rst_rd_data", rd_data, 64'h0);

    $display("[TB] bypass and release forwarding");
    applyStimulus(mk(1, 4, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0));
    #1;
    compareVal("bypass_after_edge", rd_data[XLEN-1:0], 32'hA5A5A5A5);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 9, 4, 9, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 1, 9, 32'h99, 0, 0, 4, 9, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 4, 0, 0, 0));

    $display("[TB] pending counter ramp");
    for (int i = 1; i < 32; i++) begin
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, AW'(i), AW'(i), AW'(i - 1), 0, 0, 0));
      #1;
      compareVal("ramp_up_cnt", pend_cnt, 6'(i));
    end
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 5, 5, 31, 0, 0, 0));
    #1;
    compareVal("reclaim_cnt", pend_cnt, 6'd31);
    for (int i = 1; i < 32; i++) begin
      applyStimulus(mk(0, 0, 0, 1, AW'(i), 32'(i) * 3, 0, 0, AW'(i), AW'(i + 1), 0, 0, 0));
      #1;
      compareVal("ramp_down_cnt", pend_cnt, 6'(31 - i));
    end
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 31, 1, 0, 0, 0));
    #1;
    compareVal("final_x31", rd_data[XLEN-1:0], 32'd93);
    compareVal("final_ready", rd_ready, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
